mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Load/store sequencer that sits directly upstream of the memory stage. It drives the stage's write enable, address and write data, and consumes its read data. It adds byte and halfword accesses on top of the word-only memory: read-modify-write for stores, lane extraction with sign/zero extension for loads. Misaligned accesses are rejected without touching memory.

Parameters:
- ADDR_W, 32, width of Addr and Mem_Addr.
- DATA_W, 32, data width. Fixed at 32; byte-lane logic assumes 4 lanes.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  request strobe; sampled only in IDLE.
- IsStore  in  1  1 = store, 0 = load.
- Size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved (treated as misaligned).
- SignExt  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- Addr  in  32  byte address.
- StoreData  in  32  store source; sub-word data is taken from the low bits.
- Mem_WrEn  out  1  to the memory stage's write enable.
- Mem_Addr  out  32  to the memory stage's address; the stage uses bits [11:2].
- Mem_DataIn  out  32  to the memory stage's write data.
- Mem_DataOut  in  32  from the memory stage's read data.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle completion pulse.
- Err  out  1  valid with Done: 1 = misaligned/reserved, no access performed.
- LoadData  out  32  load result; holds until the next load completes.

Behaviour:
- Memory model: write commits at the rising edge while Mem_WrEn = 1. Read is synchronous: Mem_DataOut is valid in the cycle after the address is presented with Mem_WrEn = 0.
- Byte order is little-endian. Byte lane k = Addr[1:0] occupies bits [8k+7:8k]. The half at Addr[1] = 1 occupies bits [31:16].
- Misaligned when: Size = 01 and Addr[0] = 1; Size = 10 and Addr[1:0] != 0; or Size = 11.
- At IDLE with Start = 1, the request is latched into internal registers (addr, size, data, op, sext). Inputs are ignored at all other times. Start while Busy is dropped; no queueing.
- FSM states: IDLE, READ, CAPT, MERGE, WRITE, DONE, ERR.
  - IDLE -> ERR when misaligned.
  - IDLE -> WRITE for a word store.
  - IDLE -> READ for every other access.
  - READ -> CAPT for a load; READ -> MERGE for a sub-word store.
  - CAPT -> DONE. MERGE -> WRITE. WRITE -> DONE.
  - DONE -> IDLE. ERR -> IDLE.
- Per-state actions:
  - READ: Mem_WrEn = 0, Mem_Addr = latched addr.
  - CAPT: LoadData is registered at the end of this cycle from the selected lane, extended per sext. A word load passes the word through unchanged.
  - MERGE: Mem_DataIn is registered as Mem_DataOut with only the target lane(s) replaced by the low byte/half of the latched data.
  - WRITE: Mem_WrEn = 1, Mem_Addr = latched addr. Mem_DataIn = merged word, or the latched data for a word store.
  - DONE: Done = 1, Err = 0.
  - ERR: Done = 1, Err = 1. Mem_WrEn never asserts and LoadData is unchanged.
- Mem_WrEn is decoded from the state register only, high solely in WRITE, and glitch-free.
- Latency, counted from the Start-sampling edge at cycle T:
  - word store: WRITE T+1, Done T+2.
  - load: Done T+3.
  - sub-word store: WRITE T+3, Done T+4.
  - misaligned: Done/Err T+1.
- Mem_Addr and Mem_DataIn hold their last value outside active states.
- Reset (asynchronous, Reset = 0):
  - state returns to IDLE.
  - Mem_WrEn, Busy, Done, Err = 0.
  - LoadData, Mem_Addr, Mem_DataIn = 0.
  - Reset during WRITE deasserts Mem_WrEn immediately, with no clock edge required.
  - After release, the first Start is accepted normally.
- Back-to-back: Start may be high in the cycle after DONE (state is IDLE), giving a 1-cycle gap between accesses.

Test Plan:
- Word store then load: store 0xDEADBEEF at 0x10 -> Mem_WrEn high exactly one cycle (T+1), Done at T+2. Load word 0x10 -> Done at T+3, LoadData = 0xDEADBEEF.
- Byte store RMW: word 0x10 = 0x11223344, store byte 0xAB at 0x12 -> Mem_WrEn high only at T+3, word becomes 0x11AB3344, Done at T+4.
- Sub-word loads: word 0x20 = 0x80F07F01.
  - byte 0x23, SignExt = 1 -> 0xFFFFFF80.
  - byte 0x23, SignExt = 0 -> 0x00000080.
  - half 0x20, SignExt = 1 -> 0x00007F01.
  - half 0x22, SignExt = 1 -> 0xFFFF80F0.
- Misaligned: word load at 0x21, half store at 0x23, Size = 11 -> each gives Done = Err = 1 at T+1, Mem_WrEn never high, memory and LoadData unchanged.
- Protocol: Start pulsed while Busy during a sub-word store -> ignored, single Done. Start in the cycle after Done -> accepted.
- Reset mid-op: Reset = 0 asserted asynchronously during WRITE of a byte store -> Mem_WrEn falls within the same cycle, all outputs 0, Busy = 0. The next word store after release completes at T+2.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - request, response and memory-stage signals of the load/store sequencer
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              Start;
  logic              IsStore;
  logic [1:0]        Size;
  logic              SignExt;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] StoreData;
  logic              Busy;
  logic              Done;
  logic              Err;
  logic [DATA_W-1:0] LoadData;
  logic              Mem_WrEn;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Mem_DataIn;
  logic [DATA_W-1:0] Mem_DataOut;

  modport master (
    output Start, IsStore, Size, SignExt, Addr, StoreData, Mem_DataOut,
    input  Busy, Done, Err, LoadData, Mem_WrEn, Mem_Addr, Mem_DataIn
  );

  modport slave (
    input  Start, IsStore, Size, SignExt, Addr, StoreData, Mem_DataOut,
    output Busy, Done, Err, LoadData, Mem_WrEn, Mem_Addr, Mem_DataIn
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - byte/half/word load-store sequencer in front of a word-only memory stage
module mem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic             Clk,
  input logic             Reset,
  mem_access_ctrl_if.slave bus
);

  // WRITE is the only state with bit 3 set so the write enable is a bare flop output.
  typedef enum logic [3:0] {
    IDLE  = 4'b0000,
    READ  = 4'b0001,
    CAPT  = 4'b0010,
    MERGE = 4'b0011,
    DONE  = 4'b0100,
    ERR   = 4'b0101,
    WRITE = 4'b1000
  } stateT;

  stateT             state, nextState;
  logic [1:0]        laneQ;
  logic [1:0]        sizeQ;
  logic [15:0]       dataQ;
  logic              storeQ;
  logic              sextQ;
  logic [ADDR_W-1:0] memAddrQ;
  logic [DATA_W-1:0] memDataInQ;
  logic [DATA_W-1:0] loadDataQ;
  logic              misaligned;
  logic              accept;
  logic              wordStore;
  logic              busy, done, err;
  logic [7:0]        byteVal;
  logic [15:0]       halfVal;
  logic [DATA_W-1:0] extracted;
  logic [DATA_W-1:0] merged;

  assign misaligned = (bus.Size == 2'b11) ||
                      (bus.Size == 2'b01 && bus.Addr[0]) ||
                      (bus.Size == 2'b10 && bus.Addr[1:0] != 2'b00);
  assign accept     = (state == IDLE) && bus.Start;
  assign wordStore  = bus.IsStore && (bus.Size == 2'b10);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    busy      = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus.Start) begin
          if (misaligned)     nextState = ERR;
          else if (wordStore) nextState = WRITE;
          else                nextState = READ;
        end
      end
      READ:  nextState = storeQ ? MERGE : CAPT;
      CAPT:  nextState = DONE;
      MERGE: nextState = WRITE;
      WRITE: nextState = DONE;
      DONE: begin
        done      = 1'b1;
        nextState = IDLE;
      end
      ERR: begin
        done      = 1'b1;
        err       = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    byteVal = bus.Mem_DataOut[{laneQ, 3'b000} +: 8];
    halfVal = laneQ[1] ? bus.Mem_DataOut[31:16] : bus.Mem_DataOut[15:0];
    case (sizeQ)
      2'b00:   extracted = {{24{sextQ & byteVal[7]}}, byteVal};
      2'b01:   extracted = {{16{sextQ & halfVal[15]}}, halfVal};
      default: extracted = bus.Mem_DataOut;
    endcase
  end

  always_comb begin
    merged = bus.Mem_DataOut;
    if (sizeQ == 2'b00)  merged[{laneQ, 3'b000} +: 8] = dataQ[7:0];
    else if (laneQ[1])   merged[31:16] = dataQ;
    else                 merged[15:0]  = dataQ;
  end

  // Memory-facing registers only move for accepted, aligned requests.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      laneQ      <= '0;
      sizeQ      <= '0;
      dataQ      <= '0;
      storeQ     <= 1'b0;
      sextQ      <= 1'b0;
      memAddrQ   <= '0;
      memDataInQ <= '0;
      loadDataQ  <= '0;
    end else begin
      if (accept) begin
        laneQ  <= bus.Addr[1:0];
        sizeQ  <= bus.Size;
        dataQ  <= bus.StoreData[15:0];
        storeQ <= bus.IsStore;
        sextQ  <= bus.SignExt;
        if (!misaligned) begin
          memAddrQ <= bus.Addr;
          if (wordStore) memDataInQ <= bus.StoreData;
        end
      end
      if (state == MERGE) memDataInQ <= merged;
      if (state == CAPT)  loadDataQ  <= extracted;
    end
  end

  assign bus.Mem_WrEn   = state[3];
  assign bus.Mem_Addr   = memAddrQ;
  assign bus.Mem_DataIn = memDataInQ;
  assign bus.LoadData   = loadDataQ;
  assign bus.Busy       = busy;
  assign bus.Done       = done;
  assign bus.Err        = err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl with a byte-level reference memory
module tb_mem_access_ctrl;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  mem_access_ctrl_if bus ();
  mem_access_ctrl dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  logic [31:0] memArr [0:1023] = '{default: 32'h0};
  always @(posedge Clk) begin
    if (bus.Mem_WrEn) memArr[bus.Mem_Addr[11:2]] <= bus.Mem_DataIn;
    bus.Mem_DataOut <= memArr[bus.Mem_Addr[11:2]];
  end

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  refB [0:4095];
  logic [31:0] expLoadData;

  typedef struct {
    logic        st;
    logic [1:0]  sz;
    logic        se;
    logic [31:0] addr;
    logic [31:0] data;
    bit          b2b;
    bit          pulse;
    logic [31:0] expVal;
  } vecT;

  vecT vecs [14];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] refWord(input logic [31:0] a);
    int b;
    b = int'({a[11:2], 2'b00});
    return {refB[b+3], refB[b+2], refB[b+1], refB[b]};
  endfunction

  task automatic checkAllZero(input string nm);
    check({nm, " Mem_WrEn"},   32'(bus.Mem_WrEn), 32'h0);
    check({nm, " Busy"},       32'(bus.Busy), 32'h0);
    check({nm, " Done"},       32'(bus.Done), 32'h0);
    check({nm, " Err"},        32'(bus.Err), 32'h0);
    check({nm, " LoadData"},   bus.LoadData, 32'h0);
    check({nm, " Mem_Addr"},   bus.Mem_Addr, 32'h0);
    check({nm, " Mem_DataIn"}, bus.Mem_DataIn, 32'h0);
  endtask

  task automatic runOp(input logic st, input logic [1:0] sz, input logic se,
                       input logic [31:0] a, input logic [31:0] d,
                       input bit b2b, input bit pulse, input bit chk,
                       input logic [31:0] expVal, input string nm);
    bit          mis;
    int          nb, base, lat, expWrCycle;
    int          doneCycle, doneCount, wrCount, wrCycle;
    logic        errSeen, busyFirst, busyLast;
    logic [31:0] v, newWord;
    mis  = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    nb   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    base = int'(a[11:0]);
    if (!mis && !st) begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v = v | (32'(refB[base+i]) << (8*i));
      if (se && nb < 4 && v[8*nb-1]) v = v | ~((32'h1 << (8*nb)) - 32'h1);
      expLoadData = v;
    end
    if (!mis && st) for (int i = 0; i < nb; i++) refB[base+i] = d[8*i +: 8];
    newWord    = refWord(a);
    lat        = mis ? 1 : !st ? 3 : (sz == 2'b10) ? 2 : 4;
    expWrCycle = (st && !mis) ? lat - 1 : 0;

    if (!b2b) @(negedge Clk);
    bus.Start     = 1'b1;
    bus.IsStore   = st;
    bus.Size      = sz;
    bus.SignExt   = se;
    bus.Addr      = a;
    bus.StoreData = d;
    @(posedge Clk);
    doneCycle = 0; doneCount = 0; wrCount = 0; wrCycle = 0;
    errSeen = 1'b0; busyFirst = 1'b0; busyLast = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge Clk);
      if (n == 1) busyFirst = bus.Busy;
      if (bus.Mem_WrEn) begin
        wrCount++;
        wrCycle = n;
        check({nm, " write addr"}, bus.Mem_Addr, a);
        check({nm, " write data"}, bus.Mem_DataIn, newWord);
      end
      if (bus.Done) begin
        doneCount++;
        if (doneCycle == 0) begin
          doneCycle = n;
          errSeen   = bus.Err;
        end
      end
      bus.IsStore   = 1'($urandom);
      bus.Size      = 2'($urandom);
      bus.SignExt   = 1'($urandom);
      bus.Addr      = $urandom;
      bus.StoreData = $urandom;
      if (doneCycle != 0 && n == doneCycle + 1) begin
        busyLast  = bus.Busy;
        bus.Start = 1'b0;
        break;
      end
      bus.Start = pulse && (doneCycle == 0 || doneCycle == n);
    end
    bus.Start = 1'b0;
    check({nm, " done cycle"}, 32'(doneCycle), 32'(lat));
    check({nm, " done count"}, 32'(doneCount), 32'h1);
    check({nm, " err"},        32'(errSeen), 32'(mis));
    check({nm, " write count"}, 32'(wrCount), (st && !mis) ? 32'h1 : 32'h0);
    check({nm, " write cycle"}, 32'(wrCycle), 32'(expWrCycle));
    check({nm, " busy first"}, 32'(busyFirst), 32'h1);
    check({nm, " busy after"}, 32'(busyLast), 32'h0);
    check({nm, " load data"},  bus.LoadData, expLoadData);
    check({nm, " mem word"},   memArr[a[11:2]], newWord);
    if (chk) check({nm, " table value"}, st ? memArr[a[11:2]] : bus.LoadData, expVal);
  endtask

  initial begin
    logic        st, se;
    logic [1:0]  sz;
    logic [31:0] a;
    bus.Start = 1'b0; bus.IsStore = 1'b0; bus.Size = 2'b00; bus.SignExt = 1'b0;
    bus.Addr = 32'h0; bus.StoreData = 32'h0;
    for (int i = 0; i < 4096; i++) refB[i] = 8'h00;
    expLoadData = 32'h0;

    #1 Reset = 1'b0;
    repeat (3) @(negedge Clk);
    checkAllZero("reset");
    Reset = 1'b1;

    vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 1'b0, 1'b0, 32'h11223344};
    vecs[3]  = '{1'b1, 2'd0, 1'b0, 32'h12, 32'hFFFFFFAB, 1'b0, 1'b1, 32'h11AB3344};
    vecs[4]  = '{1'b1, 2'd2, 1'b0, 32'h20, 32'h80F07F01, 1'b1, 1'b0, 32'h80F07F01};
    vecs[5]  = '{1'b0, 2'd0, 1'b1, 32'h23, 32'h0,        1'b0, 1'b0, 32'hFFFFFF80};
    vecs[6]  = '{1'b0, 2'd0, 1'b0, 32'h23, 32'h0,        1'b1, 1'b0, 32'h00000080};
    vecs[7]  = '{1'b0, 2'd1, 1'b1, 32'h20, 32'h0,        1'b0, 1'b0, 32'h00007F01};
    vecs[8]  = '{1'b0, 2'd1, 1'b1, 32'h22, 32'h0,        1'b0, 1'b1, 32'hFFFF80F0};
    vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h21, 32'h0,        1'b0, 1'b0, 32'hFFFF80F0};
    vecs[10] = '{1'b1, 2'd1, 1'b0, 32'h23, 32'h00005555, 1'b1, 1'b0, 32'h80F07F01};
    vecs[11] = '{1'b0, 2'd3, 1'b1, 32'h20, 32'h0,        1'b0, 1'b0, 32'hFFFF80F0};
    vecs[12] = '{1'b1, 2'd1, 1'b0, 32'h22, 32'h0000BEEF, 1'b0, 1'b1, 32'hBEEF7F01};
    vecs[13] = '{1'b0, 2'd1, 1'b0, 32'h22, 32'h0,        1'b1, 1'b0, 32'h0000BEEF};
    for (int i = 0; i < 14; i++)
      runOp(vecs[i].st, vecs[i].sz, vecs[i].se, vecs[i].addr, vecs[i].data,
            vecs[i].b2b, vecs[i].pulse, 1'b1, vecs[i].expVal, $sformatf("vec%0d", i));

    @(negedge Clk);
    bus.Start = 1'b1; bus.IsStore = 1'b1; bus.Size = 2'b00; bus.SignExt = 1'b0;
    bus.Addr = 32'h11; bus.StoreData = 32'h000000CC;
    @(posedge Clk);
    @(negedge Clk);
    bus.Start = 1'b0;
    repeat (2) @(negedge Clk);
    check("rst mid wren before", 32'(bus.Mem_WrEn), 32'h1);
    #2 Reset = 1'b0;
    #1 checkAllZero("rst mid");
    @(negedge Clk);
    check("rst mid mem word", memArr[4], refWord(32'h10));
    Reset = 1'b1;
    expLoadData = 32'h0;
    runOp(1'b1, 2'd2, 1'b0, 32'h30, 32'h12345678, 1'b0, 1'b0, 1'b1, 32'h12345678, "post reset");

    for (int k = 0; k < 60; k++) begin
      st = 1'($urandom);
      sz = 2'($urandom);
      se = 1'($urandom);
      a  = $urandom_range(0, 255);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        else if (sz == 2'b10) a[1:0] = 2'b00;
      end
      runOp(st, sz, se, a, $urandom, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            1'b0, 32'h0, $sformatf("rand%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
